// File: rtl/kb_scancode_buffer_pkg.sv
// Scancode constants, decoder state encodings and the set-2 to ASCII lookup.
// Pure definitions: no latency, no flow control.
// Shared by the decoder top level and its testbench.
package kb_scancode_buffer_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } kb_state_t;

  // Returns {valid, ascii[6:0]}; valid = 0 for keys with no printable mapping.
  function automatic logic [7:0] sc_to_ascii(input logic [7:0] sc, input logic shift);
    logic [6:0] lo;
    logic [6:0] hi;
    logic       vld;
    lo  = '0;
    hi  = '0;
    vld = 1'b1;
    case (sc)
      8'h1C: {lo, hi} = {7'h61, 7'h41};  8'h32: {lo, hi} = {7'h62, 7'h42};
      8'h21: {lo, hi} = {7'h63, 7'h43};  8'h23: {lo, hi} = {7'h64, 7'h44};
      8'h24: {lo, hi} = {7'h65, 7'h45};  8'h2B: {lo, hi} = {7'h66, 7'h46};
      8'h34: {lo, hi} = {7'h67, 7'h47};  8'h33: {lo, hi} = {7'h68, 7'h48};
      8'h43: {lo, hi} = {7'h69, 7'h49};  8'h3B: {lo, hi} = {7'h6A, 7'h4A};
      8'h42: {lo, hi} = {7'h6B, 7'h4B};  8'h4B: {lo, hi} = {7'h6C, 7'h4C};
      8'h3A: {lo, hi} = {7'h6D, 7'h4D};  8'h31: {lo, hi} = {7'h6E, 7'h4E};
      8'h44: {lo, hi} = {7'h6F, 7'h4F};  8'h4D: {lo, hi} = {7'h70, 7'h50};
      8'h15: {lo, hi} = {7'h71, 7'h51};  8'h2D: {lo, hi} = {7'h72, 7'h52};
      8'h1B: {lo, hi} = {7'h73, 7'h53};  8'h2C: {lo, hi} = {7'h74, 7'h54};
      8'h3C: {lo, hi} = {7'h75, 7'h55};  8'h2A: {lo, hi} = {7'h76, 7'h56};
      8'h1D: {lo, hi} = {7'h77, 7'h57};  8'h22: {lo, hi} = {7'h78, 7'h58};
      8'h35: {lo, hi} = {7'h79, 7'h59};  8'h1A: {lo, hi} = {7'h7A, 7'h5A};
      8'h16: {lo, hi} = {7'h31, 7'h21};  8'h1E: {lo, hi} = {7'h32, 7'h40};
      8'h26: {lo, hi} = {7'h33, 7'h23};  8'h25: {lo, hi} = {7'h34, 7'h24};
      8'h2E: {lo, hi} = {7'h35, 7'h25};  8'h36: {lo, hi} = {7'h36, 7'h5E};
      8'h3D: {lo, hi} = {7'h37, 7'h26};  8'h3E: {lo, hi} = {7'h38, 7'h2A};
      8'h46: {lo, hi} = {7'h39, 7'h28};  8'h45: {lo, hi} = {7'h30, 7'h29};
      8'h0E: {lo, hi} = {7'h60, 7'h7E};  8'h4E: {lo, hi} = {7'h2D, 7'h5F};
      8'h55: {lo, hi} = {7'h3D, 7'h2B};  8'h54: {lo, hi} = {7'h5B, 7'h7B};
      8'h5B: {lo, hi} = {7'h5D, 7'h7D};  8'h5D: {lo, hi} = {7'h5C, 7'h7C};
      8'h4C: {lo, hi} = {7'h3B, 7'h3A};  8'h52: {lo, hi} = {7'h27, 7'h22};
      8'h41: {lo, hi} = {7'h2C, 7'h3C};  8'h49: {lo, hi} = {7'h2E, 7'h3E};
      8'h4A: {lo, hi} = {7'h2F, 7'h3F};  8'h29: {lo, hi} = {7'h20, 7'h20};
      8'h5A: {lo, hi} = {7'h0D, 7'h0D};  8'h66: {lo, hi} = {7'h08, 7'h08};
      default: vld = 1'b0;
    endcase
    return {vld, shift ? hi : lo};
  endfunction

endpackage

// File: rtl/kb_char_fifo.sv
// First-word-fall-through character queue with occupancy count and sticky overflow.
// Latency: a push is visible at the head one cycle later; pop advances the head next cycle.
// Backpressure: none upstream; a push into a full queue without a pop is dropped and flagged.
module kb_char_fifo #(
  parameter int DEPTH  = 16,
  parameter int CHAR_W = 7,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push_vld,
  input  logic [CHAR_W-1:0] push_dat,
  input  logic              pop_req,
  output logic [CHAR_W-1:0] head_dat,
  output logic              not_empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;
  logic              do_push;
  logic              drop;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop_req & not_empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push   = push_vld & (~full | do_pop);
  assign drop      = push_vld & full & ~do_pop;
  assign head_dat  = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/kb_scancode_buffer.sv
// Set-2 scancode decoder (shift, break, extended prefixes) feeding a CPU-facing char FIFO.
// Latency: a byte strobed at edge N is at the FIFO head after edge N.
// Backpressure: none to the PS/2 side; characters arriving while full are dropped and flagged.
module kb_scancode_buffer
  import kb_scancode_buffer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int CHAR_W   = 7,
  parameter int SHIFT_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  input  logic                     KB_read_en,
  input  logic                     KB_clear,
  output logic                     KB_status,
  output logic [CHAR_W-1:0]        KB_data,
  output logic                     buf_full,
  output logic [$clog2(DEPTH):0]   KB_count,
  output logic                     KB_overflow
);

  kb_state_t   state_q;
  kb_state_t   state_d;
  logic        shift_q;
  logic        shift_set;
  logic        shift_clr;
  logic        push_vld;
  logic [6:0]  push_char;
  logic [7:0]  lut;
  logic        is_shift;

  assign lut      = sc_to_ascii(rx_data, shift_q & (SHIFT_EN != 0));
  assign is_shift = (rx_data == SC_LSHIFT) || (rx_data == SC_RSHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           state_q <= ST_IDLE;
    else if (KB_clear) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_done) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_BREAK)    state_d = ST_BREAK;
          else if (rx_data == SC_EXT) state_d = ST_EXT;
        end
        ST_EXT:  state_d = (rx_data == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    push_vld  = 1'b0;
    push_char = '0;
    shift_set = 1'b0;
    shift_clr = 1'b0;
    if (rx_done) begin
      case (state_q)
        ST_IDLE: begin
          if (is_shift) begin
            shift_set = 1'b1;
          end else if (rx_data != SC_BREAK && rx_data != SC_EXT && lut[7]) begin
            push_vld  = 1'b1;
            push_char = lut[6:0];
          end
        end
        ST_BREAK: shift_clr = is_shift;
        ST_EXT: begin
          if (rx_data == SC_ENTER) begin
            push_vld  = 1'b1;
            push_char = 7'h0D;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            shift_q <= 1'b0;
    else if (KB_clear)  shift_q <= 1'b0;
    else if (shift_set) shift_q <= 1'b1;
    else if (shift_clr) shift_q <= 1'b0;
  end

  kb_char_fifo #(
    .DEPTH  (DEPTH),
    .CHAR_W (CHAR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (KB_clear),
    .push_vld  (push_vld),
    .push_dat  (CHAR_W'(push_char)),
    .pop_req   (KB_read_en),
    .head_dat  (KB_data),
    .not_empty (KB_status),
    .full      (buf_full),
    .count     (KB_count),
    .overflow  (KB_overflow)
  );

endmodule
